pv2000_ram_arbiter: RTL and testbench

//  Sequences and shares the 64 KiB main RAM port (spram, 16-bit addr) between the cartridge erase engine,
//  the HPS cartridge download (ioctl) and the Z80 CPU. Replaces ad-hoc top-level muxing with a

---
 rtl/pv2000_mem_pkg.sv | 28 ++
 rtl/pv2000_clear_engine.sv | 37 +++
 rtl/pv2000_ram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_pv2000_ram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pv2000_mem_pkg.sv
// pv2000_mem_pkg: shared types and constants for the PV-2000 main RAM arbiter.
package pv2000_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DLOAD = 2'd1,
        ERASE = 2'd2,
        HOLD  = 2'd3
    } arb_state_t;

    localparam int RAM_AW  = 16;
    localparam int VRAM_AW = 14;

    localparam logic [RAM_AW-1:0] DEF_CART_BASE   = 16'hC000;
    localparam logic [RAM_AW-1:0] DEF_ERASE_START = 16'h7000;
    localparam logic [RAM_AW-1:0] DEF_ERASE_END   = 16'hFFFF;
    localparam logic [7:0]        DEF_HOLD_CYCLES = 8'd255;

    // Cartridge slots land at the cartridge base; the sum wraps modulo 64 KiB.
    function automatic logic [RAM_AW-1:0] dload_addr(
        input logic [RAM_AW-1:0] addr,
        input logic [7:0]        index,
        input logic [RAM_AW-1:0] cart_base
    );
        return addr + ((index == 8'd0) ? {RAM_AW{1'b0}} : cart_base);
    endfunction

endpackage

// File: rtl/pv2000_clear_engine.sv
// pv2000_clear_engine: after a start pulse issues one write per cycle across [FIRST, LAST].
module pv2000_clear_engine #(
    parameter int            AW    = 16,
    parameter logic [AW-1:0] FIRST = {AW{1'b0}},
    parameter logic [AW-1:0] LAST  = {AW{1'b1}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] addr,
    output logic          wren,
    output logic          last
);
    logic [AW-1:0] cnt_r;
    logic          active_r;

    // Address walker; stopping on the compare keeps LAST = all-ones from wrapping to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {AW{1'b0}};
            active_r <= 1'b0;
        end else if (start) begin
            cnt_r    <= FIRST;
            active_r <= 1'b1;
        end else if (abort || last) begin
            active_r <= 1'b0;
        end else if (active_r) begin
            cnt_r <= cnt_r + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    assign addr = cnt_r;
    assign wren = active_r;
    assign last = active_r && (cnt_r == LAST);

endmodule

// File: rtl/pv2000_ram_arbiter.sv
// pv2000_ram_arbiter: shares the main RAM port between download, erase and the Z80 and holds
// sys_reset after each operation. Define PV2000_VRAM_ERASE_EN to also clear VRAM during erase.
module pv2000_ram_arbiter
    import pv2000_mem_pkg::*;
#(
    parameter logic [RAM_AW-1:0] ERASE_START = DEF_ERASE_START,
    parameter logic [RAM_AW-1:0] ERASE_END   = DEF_ERASE_END,
    parameter logic [RAM_AW-1:0] CART_BASE   = DEF_CART_BASE,
    parameter logic [7:0]        HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              erase_req,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [RAM_AW-1:0] cpu_a,
    input  logic              cpu_we_n,
    input  logic [7:0]        cpu_do,
    output logic              cpu_wait,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wren,
    output logic [7:0]        ram_data,
    output logic              busy,
    output logic              erase_done,
`ifdef PV2000_VRAM_ERASE_EN
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_wren,
    output logic [7:0]         vram_data,
`endif
    output logic              sys_reset
);
    arb_state_t        state_r, state_s;
    logic [7:0]        hold_r;
    logic              erase_req_d_r, erase_pend_r;
    logic              erase_rise_s, eng_start_s, eng_abort_s, hold_load_s, fin_s;
    logic [RAM_AW-1:0] ram_clr_addr_s;
    logic              ram_clr_wren_s, ram_clr_last_s;
    logic              unused_s;

    assign unused_s     = ^ioctl_addr[24:16];
    assign erase_rise_s = erase_req && !erase_req_d_r;
    assign eng_start_s  = (state_r != ERASE) && (state_s == ERASE);
    assign eng_abort_s  = (state_r == ERASE) && ioctl_download;
    assign hold_load_s  = (state_r != HOLD) && (state_s == HOLD);

    pv2000_clear_engine #(.AW(RAM_AW), .FIRST(ERASE_START), .LAST(ERASE_END)) u_ram_clear (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .start (eng_start_s),
        .abort (eng_abort_s),
        .addr  (ram_clr_addr_s),
        .wren  (ram_clr_wren_s),
        .last  (ram_clr_last_s)
    );

`ifdef PV2000_VRAM_ERASE_EN
    logic vram_clr_last_s;

    pv2000_clear_engine #(.AW(VRAM_AW), .FIRST(14'h0000), .LAST(14'h3FFF)) u_vram_clear (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .start (eng_start_s),
        .abort (eng_abort_s),
        .addr  (vram_addr),
        .wren  (vram_wren),
        .last  (vram_clr_last_s)
    );

    assign vram_data = 8'h00;
    assign fin_s     = (ram_clr_last_s || !ram_clr_wren_s) && (vram_clr_last_s || !vram_wren);
`else
    assign fin_s     = ram_clr_last_s;
`endif

    // State register; power-up starts in HOLD so the system sees a full reset hold.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= HOLD;
        end else begin
            state_r <= state_s;
        end
    end

    // Erase request edge latch; an aborted erase re-arms itself.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            erase_req_d_r <= 1'b0;
            erase_pend_r  <= 1'b0;
        end else begin
            erase_req_d_r <= erase_req;
            if (erase_rise_s || eng_abort_s) begin
                erase_pend_r <= 1'b1;
            end else if (eng_start_s) begin
                erase_pend_r <= 1'b0;
            end
        end
    end

    // Hold counter, reloaded on each entry into HOLD.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_r <= HOLD_CYCLES;
        end else if (hold_load_s) begin
            hold_r <= HOLD_CYCLES;
        end else if ((state_r == HOLD) && (hold_r != 8'd0)) begin
            hold_r <= hold_r - 8'd1;
        end
    end

    // Next-state logic: download beats erase beats CPU.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ioctl_download) begin
                    state_s = DLOAD;
                end else if (erase_pend_r) begin
                    state_s = ERASE;
                end else begin
                    state_s = IDLE;
                end
            end
            DLOAD: begin
                if (!ioctl_download) begin
                    state_s = HOLD;
                end else begin
                    state_s = DLOAD;
                end
            end
            ERASE: begin
                if (ioctl_download) begin
                    state_s = DLOAD;
                end else if (fin_s) begin
                    state_s = HOLD;
                end else begin
                    state_s = ERASE;
                end
            end
            HOLD: begin
                if (ioctl_download) begin
                    state_s = DLOAD;
                end else if (hold_r <= 8'd1) begin
                    state_s = erase_pend_r ? ERASE : IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = HOLD;
            end
        endcase
    end

    // RAM port mux and status outputs.
    always_comb begin
        ram_addr   = {RAM_AW{1'b0}};
        ram_wren   = 1'b0;
        ram_data   = 8'h00;
        cpu_wait   = 1'b1;
        busy       = 1'b0;
        erase_done = 1'b0;
        sys_reset  = 1'b1;
        case (state_r)
            IDLE: begin
                ram_addr  = cpu_a;
                ram_wren  = !cpu_we_n;
                ram_data  = cpu_do;
                cpu_wait  = 1'b0;
                sys_reset = 1'b0;
            end
            DLOAD: begin
                ram_addr = dload_addr(ioctl_addr[15:0], ioctl_index, CART_BASE);
                ram_wren = ioctl_wr;
                ram_data = ioctl_dout;
                busy     = 1'b1;
            end
            ERASE: begin
                ram_addr   = ram_clr_addr_s;
                ram_wren   = ram_clr_wren_s;
                busy       = 1'b1;
                erase_done = fin_s && !ioctl_download;
            end
            HOLD: begin
                busy = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pv2000_ram_arbiter.sv
// tb_pv2000_ram_arbiter: random CPU/download traffic and erase scenarios against a byte-image model.
module tb_pv2000_ram_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        erase_req, ioctl_download, ioctl_wr, cpu_we_n;
    logic [7:0]  ioctl_index, ioctl_dout, cpu_do;
    logic [24:0] ioctl_addr;
    logic [15:0] cpu_a;
    logic        cpu_wait, ram_wren, busy, erase_done, sys_reset;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
`ifdef PV2000_VRAM_ERASE_EN
    logic [13:0] vram_addr;
    logic        vram_wren;
    logic [7:0]  vram_data;
`endif

    logic [7:0]  mem [0:65535];
    logic [7:0]  ram_q;
    logic [7:0]  exp_mem [0:65535];
    bit          exp_valid [0:65535];
    int          n_vec = 0;
    int          n_err = 0;

    pv2000_ram_arbiter dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .erase_req      (erase_req),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .cpu_a          (cpu_a),
        .cpu_we_n       (cpu_we_n),
        .cpu_do         (cpu_do),
        .cpu_wait       (cpu_wait),
        .ram_addr       (ram_addr),
        .ram_wren       (ram_wren),
        .ram_data       (ram_data),
        .busy           (busy),
        .erase_done     (erase_done),
`ifdef PV2000_VRAM_ERASE_EN
        .vram_addr      (vram_addr),
        .vram_wren      (vram_wren),
        .vram_data      (vram_data),
`endif
        .sys_reset      (sys_reset)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous single-port RAM with one-cycle read latency.
    always @(posedge clk_sys) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk_sys);
        #1;
    endtask

    // Counts sys_reset cycles before the arbiter grants the CPU or starts an erase.
    task automatic measure_hold(input string tag);
        int n = 0;
        while (sys_reset && !busy && n < 1000) begin
            n++;
            step;
        end
        check_eq(tag, n, 255);
    endtask

    task automatic wait_busy(input string tag);
        int g = 0;
        while (!busy && g < 20) begin
            g++;
            step;
        end
        check_eq(tag, busy, 1);
    endtask

    task automatic cpu_write_read(input logic [15:0] a, input logic [7:0] d);
        step;
        cpu_a = a; cpu_do = d; cpu_we_n = 1'b0;
        #1;
        check_eq("cpu_wr_en", ram_wren, 1);
        check_eq("cpu_wr_addr", ram_addr, a);
        check_eq("cpu_wait_idle", cpu_wait, 0);
        exp_mem[a] = d; exp_valid[a] = 1'b1;
        step;
        cpu_we_n = 1'b1;
        step;
        check_eq("cpu_rd_after_wr", ram_q, d);
    endtask

    task automatic cpu_read(input logic [15:0] a);
        step;
        cpu_a = a; cpu_we_n = 1'b1;
        step;
        check_eq("cpu_rd", ram_q, exp_mem[a]);
    endtask

    task automatic dl_begin(input logic [7:0] idx);
        step;
        ioctl_index = idx; ioctl_download = 1'b1;
        step;
        check_eq("dl_busy", busy, 1);
        check_eq("dl_cpu_wait", cpu_wait, 1);
    endtask

    task automatic dl_write(input logic [15:0] a, input logic [7:0] d);
        int t;
        t = (int'(a) + ((ioctl_index != 8'd0) ? 49152 : 0)) % 65536;
        step;
        ioctl_addr = {9'($urandom), a}; ioctl_dout = d; ioctl_wr = 1'b1;
        cpu_a = 16'($urandom); cpu_we_n = 1'b0;
        #1;
        check_eq("dl_wren", ram_wren, 1);
        check_eq("dl_addr", ram_addr, t);
        check_eq("dl_data", ram_data, d);
        exp_mem[t] = d; exp_valid[t] = 1'b1;
        step;
        ioctl_wr = 1'b0;
        #1;
        check_eq("dl_cpu_discard", ram_wren, 0);
        cpu_we_n = 1'b1;
    endtask

    task automatic dl_end;
        step;
        ioctl_download = 1'b0;
        step;
    endtask

    // Follows a full erase from its first write to its last, then applies it to the model.
    task automatic erase_watch(input string tag);
        int nw = 0, nd = 0, seq_err = 0, guard = 0;
        logic [15:0] done_a = 16'h0000;
        while (busy && guard < 40000) begin
            if (ram_wren) begin
                if (ram_addr !== 16'(28672 + nw) || ram_data !== 8'h00) seq_err++;
                nw++;
            end
            if (erase_done) begin
                nd++;
                done_a = ram_addr;
            end
            guard++;
            step;
        end
        check_eq({tag, "_writes"}, nw, 36864);
        check_eq({tag, "_done_pulses"}, nd, 1);
        check_eq({tag, "_done_addr"}, done_a, 16'hFFFF);
        check_eq({tag, "_seq_errors"}, seq_err, 0);
        for (int a = 28672; a < 65536; a++) begin
            exp_mem[a] = 8'h00; exp_valid[a] = 1'b1;
        end
    endtask

    task automatic pulse_erase;
        step;
        erase_req = 1'b1;
        step;
        erase_req = 1'b0;
    endtask

    initial begin
        int g, nd, diffs;
        reset_n = 1'b0; erase_req = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
        ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
        cpu_a = 16'd0; cpu_we_n = 1'b1; cpu_do = 8'd0;
        for (int i = 0; i < 65536; i++) exp_valid[i] = 1'b0;
        repeat (3) step;
        check_eq("rst_cpu_wait", cpu_wait, 1);
        check_eq("rst_sys_reset", sys_reset, 1);
        check_eq("rst_ram_wren", ram_wren, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_erase_done", erase_done, 0);
        reset_n = 1'b1;
        measure_hold("hold_por");
        check_eq("idle_cpu_wait", cpu_wait, 0);

        // CPU access
        cpu_write_read(16'h1234, 8'hA5);
        for (int k = 0; k < 8; k++) cpu_write_read(16'($urandom), 8'($urandom));
        cpu_read(16'h1234);

        // Downloads: cartridge offset, raw image, and wrap-around
        dl_begin(8'd1);
        for (int k = 0; k < 4; k++) dl_write(16'(k), 8'(8'h11 + 8'(k)));
        dl_end;
        measure_hold("hold_dl_cart");
        dl_begin(8'd0);
        dl_write(16'h4000, 8'h3C);
        for (int k = 0; k < 4; k++) dl_write(16'($urandom), 8'($urandom));
        dl_end;
        measure_hold("hold_dl_raw");
        dl_begin(8'($urandom_range(1, 255)));
        dl_write(16'h4000, 8'hC3);
        for (int k = 0; k < 4; k++) dl_write(16'($urandom), 8'($urandom));
        dl_end;
        measure_hold("hold_dl_wrap");
        cpu_read(16'hC000);
        cpu_read(16'hC003);
        cpu_read(16'h4000);
        cpu_read(16'h0000);

        // Full erase
        cpu_write_read(16'h7000, 8'hFF);
        cpu_write_read(16'hFFFF, 8'hFF);
        cpu_write_read(16'h6FFF, 8'hFF);
        pulse_erase;
        wait_busy("erase_start");
        check_eq("erase_first_addr", ram_addr, 16'h7000);
        erase_watch("erase");
        measure_hold("hold_erase");
        cpu_read(16'h7000);
        cpu_read(16'hFFFF);
        cpu_read(16'h6FFF);

        // Download interrupts erase at 8000; erase_req during download; erase restarts
        pulse_erase;
        wait_busy("abort_start");
        g = 0; nd = 0;
        while (ram_addr !== 16'h8000 && g < 5000) begin
            if (erase_done) nd++;
            g++;
            step;
        end
        check_eq("abort_reach_8000", ram_addr, 16'h8000);
        check_eq("abort_no_done", nd, 0);
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        step;
        check_eq("abort_in_dload", busy, 1);
        check_eq("dload_no_erase_wr", ram_wren, 0);
        pulse_erase;
        check_eq("dload_no_erase_wr2", ram_wren, 0);
        dl_write(16'h9000, 8'h77);
        dl_write(16'h0100, 8'($urandom));
        dl_end;
        measure_hold("hold_abort");
        check_eq("restart_busy", busy, 1);
        check_eq("restart_first_addr", ram_addr, 16'h7000);
        erase_watch("reerase");
        measure_hold("hold_reerase");
        g = 0;
        repeat (50) begin
            if (busy) g++;
            step;
        end
        check_eq("no_extra_erase", g, 0);
        cpu_read(16'h9000);
        cpu_read(16'h0100);

        // Reset in the middle of an erase
        pulse_erase;
        wait_busy("rst_erase_start");
        repeat (100) step;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_cpu_wait", cpu_wait, 1);
        check_eq("mid_rst_sys_reset", sys_reset, 1);
        check_eq("mid_rst_ram_wren", ram_wren, 0);
        check_eq("mid_rst_ram_addr", ram_addr, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_erase_done", erase_done, 0);
        repeat (2) step;
        reset_n = 1'b1;
        measure_hold("hold_after_rst");
        g = 0; nd = 0;
        repeat (300) begin
            if (busy) g++;
            if (erase_done) nd++;
            step;
        end
        check_eq("no_resume_busy", g, 0);
        check_eq("no_resume_done", nd, 0);
        check_eq("final_cpu_wait", cpu_wait, 0);

        diffs = 0;
        for (int a = 0; a < 65536; a++) begin
            if (exp_valid[a] && mem[a] !== exp_mem[a]) diffs++;
        end
        check_eq("mem_image", diffs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
